// File: rtl/bullscows_pkg.sv
// Shared types and constants for the bulls/cows guess evaluator.
package bullscows_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CODE_W  = DIGITS * DIGIT_W;
    localparam int unsigned IDX_W   = $clog2(DIGITS);
    localparam int unsigned PAIR_W  = 2 * IDX_W;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFinish,
        StDone
    } eval_state_t;

    // Nibble k of a code; nibble DIGITS-1 is the leftmost digit.
    function automatic logic [DIGIT_W-1:0] digit_sel(input logic [CODE_W-1:0] code,
                                                     input logic [IDX_W-1:0]  k);
        return code[k*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/guess_evaluator.sv
// Serial bulls/cows scorer: scans all secret/guess digit pairs one per cycle,
// then publishes validity and scores with a one-cycle done pulse.
module guess_evaluator
    import bullscows_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [CODE_W-1:0] secret,
    input  logic [CODE_W-1:0] guess,
    output logic              busy,
    output logic              done,
    output logic              guess_valid,
    output logic [3:0]        bulls,
    output logic [3:0]        cows,
    output logic              win
);

    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(DIGITS * DIGITS - 1);

    eval_state_t state_q, state_d;
    logic        accept;

    logic [CODE_W-1:0] secret_q, guess_q;
    logic              mode_q;
    logic [PAIR_W-1:0] pair_q;
    logic [2:0]        bull_acc_q;
    logic [3:0]        cow_acc_q;
    logic              dup_q, range_err_q;

    logic              done_q, guess_valid_q, win_q;
    logic [3:0]        bulls_q, cows_q;

    logic [IDX_W-1:0]   idx_i, idx_j;
    logic [DIGIT_W-1:0] s_i, g_i, g_j;
    logic               valid_now, score_en;

    assign idx_i = pair_q[PAIR_W-1:IDX_W];
    assign idx_j = pair_q[IDX_W-1:0];
    assign s_i   = digit_sel(secret_q, idx_i);
    assign g_i   = digit_sel(guess_q, idx_i);
    assign g_j   = digit_sel(guess_q, idx_j);

    assign valid_now = !dup_q && !range_err_q;
    assign score_en  = valid_now && !mode_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    accept  = 1'b1;
                end
            end
            StScan: begin
                if (pair_q == LAST_PAIR) state_d = StFinish;
            end
            StFinish: state_d = StDone;
            StDone: begin
                // Back-to-back request: restart the scan straight from DONE.
                if (start) begin
                    state_d = StScan;
                    accept  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            secret_q      <= '0;
            guess_q       <= '0;
            mode_q        <= 1'b0;
            pair_q        <= '0;
            bull_acc_q    <= '0;
            cow_acc_q     <= '0;
            dup_q         <= 1'b0;
            range_err_q   <= 1'b0;
            done_q        <= 1'b0;
            guess_valid_q <= 1'b0;
            bulls_q       <= '0;
            cows_q        <= '0;
            win_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                secret_q    <= secret;
                guess_q     <= guess;
                mode_q      <= mode;
                pair_q      <= '0;
                bull_acc_q  <= '0;
                cow_acc_q   <= '0;
                dup_q       <= 1'b0;
                range_err_q <= 1'b0;
            end else if (state_q == StScan) begin
                pair_q <= pair_q + 1'b1;
                if (s_i == g_j) begin
                    if (idx_i == idx_j) bull_acc_q <= bull_acc_q + 1'b1;
                    else                cow_acc_q  <= cow_acc_q + 1'b1;
                end
                if ((idx_i < idx_j) && (g_i == g_j)) dup_q <= 1'b1;
                // Every guess digit is visited once while idx_i is zero.
                if ((idx_i == '0) && (g_j > MAX_DIGIT)) range_err_q <= 1'b1;
            end else if (state_q == StFinish) begin
                done_q        <= 1'b1;
                guess_valid_q <= valid_now;
                bulls_q       <= score_en ? {1'b0, bull_acc_q} : 4'd0;
                cows_q        <= score_en ? cow_acc_q : 4'd0;
                win_q         <= score_en && (bull_acc_q == 3'(DIGITS));
            end
        end
    end

    assign busy        = (state_q == StScan) || (state_q == StFinish);
    assign done        = done_q;
    assign guess_valid = guess_valid_q;
    assign bulls       = bulls_q;
    assign cows        = cows_q;
    assign win         = win_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed bench for guess_evaluator: scoring, validation and control corners.
module tb_guess_evaluator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode  = 1'b0;
    logic [15:0] secret = '0;
    logic [15:0] guess  = '0;
    logic        busy, done, guess_valid, win;
    logic [3:0]  bulls, cows;

    int total = 0;
    int bad   = 0;

    // Done appears 17 edges after the edge that samples start.
    localparam int LAT = 17;

    guess_evaluator dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .secret      (secret),
        .guess       (guess),
        .busy        (busy),
        .done        (done),
        .guess_valid (guess_valid),
        .bulls       (bulls),
        .cows        (cows),
        .win         (win)
    );

    always #5 clock = ~clock;

    // {guess_valid, bulls, cows, win}
    function automatic logic [9:0] res();
        return {guess_valid, bulls, cows, win};
    endfunction

    task automatic launch(input logic [15:0] s, input logic [15:0] g, input logic m);
        secret = s;
        guess  = g;
        mode   = m;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            #1 lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00", {busy, done});
        end
        total++;
        if (res() !== 10'h000) begin
            bad++; $display("FAIL reset_results: got %h want 000", res());
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_exact();
        int lat;
        launch(16'h1234, 16'h1234, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL exact_busy: got %b want 1", busy);
        end
        wait_done(lat);
        total++;
        if (lat != LAT) begin
            bad++; $display("FAIL exact_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (res() !== {1'b1, 4'd4, 4'd0, 1'b1}) begin
            bad++; $display("FAIL exact_result: got %h want %h", res(), {1'b1, 4'd4, 4'd0, 1'b1});
        end
        @(posedge clock);
        #1;
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++; $display("FAIL exact_pulse: got %b want 00", {done, busy});
        end
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (res() !== {1'b1, 4'd4, 4'd0, 1'b1}) begin
            bad++; $display("FAIL exact_hold: got %h want %h", res(), {1'b1, 4'd4, 4'd0, 1'b1});
        end
    endtask

    task automatic test_score(input string name, input logic [15:0] s, input logic [15:0] g,
                              input logic m, input logic [9:0] exp);
        int lat;
        launch(s, g, m);
        // Operand changes after acceptance must not matter.
        secret = 16'h5678;
        guess  = 16'hFFFF;
        mode   = ~m;
        wait_done(lat);
        total++;
        if (lat != LAT) begin
            bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
        end
        total++;
        if (res() !== exp) begin
            bad++; $display("FAIL %s: got %h want %h", name, res(), exp);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_ignored_start();
        int lat;
        int extra;
        launch(16'h1234, 16'h4321, 1'b0);
        repeat (4) @(posedge clock);
        #1 launch(16'h1234, 16'h1234, 1'b0);
        wait_done(lat);
        total++;
        // launch already consumed 5 edges from the original start.
        if (lat + 5 != LAT) begin
            bad++; $display("FAIL ignored_latency: got %0d want %0d", lat + 5, LAT);
        end
        total++;
        if (res() !== {1'b1, 4'd0, 4'd4, 1'b0}) begin
            bad++; $display("FAIL ignored_result: got %h want %h", res(), {1'b1, 4'd0, 4'd4, 1'b0});
        end
        extra = 0;
        repeat (25) begin
            @(posedge clock);
            #1 if (done === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++; $display("FAIL ignored_extra_done: got %0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(16'h1234, 16'h1562, 1'b0);
        wait_done(lat);
        total++;
        if (res() !== {1'b1, 4'd1, 4'd1, 1'b0}) begin
            bad++; $display("FAIL b2b_first: got %h want %h", res(), {1'b1, 4'd1, 4'd1, 1'b0});
        end
        launch(16'h1234, 16'h1234, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy);
        end
        wait_done(lat);
        total++;
        if (lat != LAT) begin
            bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (res() !== {1'b1, 4'd4, 4'd0, 1'b1}) begin
            bad++; $display("FAIL b2b_second: got %h want %h", res(), {1'b1, 4'd4, 4'd0, 1'b1});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        launch(16'h1234, 16'h1234, 1'b0);
        repeat (7) @(posedge clock);
        #1 reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL midreset_ctrl: got %b want 00", {busy, done});
        end
        total++;
        if (res() !== 10'h000) begin
            bad++; $display("FAIL midreset_results: got %h want 000", res());
        end
        seen = 0;
        repeat (25) begin
            @(posedge clock);
            #1 if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL midreset_activity: got %0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_score("permutation", 16'h1234, 16'h4321, 1'b0, {1'b1, 4'd0, 4'd4, 1'b0});
        test_score("partial",     16'h1234, 16'h1562, 1'b0, {1'b1, 4'd1, 4'd1, 1'b0});
        test_score("rep_secret",  16'h1111, 16'h1234, 1'b0, {1'b1, 4'd1, 4'd3, 1'b0});
        test_score("dup_guess",   16'h1234, 16'h1123, 1'b0, {1'b0, 4'd0, 4'd0, 1'b0});
        test_score("range_guess", 16'h1234, 16'h12A4, 1'b0, {1'b0, 4'd0, 4'd0, 1'b0});
        test_score("entry_ok",    16'h0000, 16'h9876, 1'b1, {1'b1, 4'd0, 4'd0, 1'b0});
        test_score("entry_dup",   16'h0000, 16'h9896, 1'b1, {1'b0, 4'd0, 4'd0, 1'b0});
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
